// File: rtl/reg_seg_display_if.sv
// Register-file debug taps into the display block, plus the board-side display lines.
// Latency: none; this is a plain signal bundle with no storage.
// Backpressure: none. The taps are free-running levels and the display lines are always valid.
interface reg_seg_display_if;
  logic [7:0]  OUT_BYTE;   // register 1 bits [7:0]
  logic [31:0] R2_WORD;    // register 2 bits [31:0]
  logic [1:0]  PAGE_SEL;   // which 16-bit page to show
  logic        FREEZE;     // hold the current snapshot
  logic [3:0]  AN;         // digit enables, active-low
  logic [6:0]  SEG;        // segments {g,f,e,d,c,b,a}, active-low
  logic        DP;         // decimal point, active-low

  // Register-file side: drives the taps and observes the display.
  modport master (
    output OUT_BYTE, R2_WORD, PAGE_SEL, FREEZE,
    input  AN, SEG, DP
  );

  // Display side: samples the taps and drives the board lines.
  modport slave (
    input  OUT_BYTE, R2_WORD, PAGE_SEL, FREEZE,
    output AN, SEG, DP
  );
endinterface

// File: rtl/reg_seg_display.sv
// Shows a selected 16-bit page of register debug taps as four hex digits on a
// multiplexed active-low 7-segment display. Optional macro BLANK_LEADING_ZERO_EN.
// Latency: a new page appears on the first digit-0 frame after a scan boundary.
// Backpressure: none. Taps are sampled only at scan boundaries and are ignored while FREEZE=1.
module reg_seg_display #(
  parameter int REFRESH_DIV = 100000  // clock cycles each digit stays lit (>=2)
) (
  input  logic            CLK,
  input  logic            RST_N,
  reg_seg_display_if.slave bus
);

  localparam int              PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_ZERO   = 7'b1000000;
  localparam logic [6:0]      SEG_BLANK  = 7'b1111111;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  // Hex nibble to active-low gfedcba pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // State
  logic [PW-1:0] presc_q, presc_d;
  digit_e        digit_q, digit_d;
  logic [15:0]   snap_q, snap_d;
  logic [1:0]    page_q, page_d;

  // Registered display outputs
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  // Combinational helpers
  logic          tc;
  logic          boundary;
  logic [15:0]   page_val;
  logic [1:0]    digit_idx;
  logic [3:0]    nib;
  logic          blank;

  // Page mux: page 3 aliases page 0.
  always_comb begin
    page_val = {8'h00, bus.OUT_BYTE};
    case (bus.PAGE_SEL)
      2'd1:    page_val = bus.R2_WORD[15:0];
      2'd2:    page_val = bus.R2_WORD[31:16];
      default: page_val = {8'h00, bus.OUT_BYTE};
    endcase
  end

  // Prescaler, digit scan and snapshot next-state. The snapshot and page move only at a scan boundary.
  always_comb begin
    presc_d  = presc_q + PW'(1);
    digit_d  = digit_q;
    snap_d   = snap_q;
    page_d   = page_q;
    tc       = (presc_q == PRESC_LAST);
    boundary = tc && (digit_q == DIG3);
    if (tc) begin
      presc_d = '0;
      case (digit_q)
        DIG0:    digit_d = DIG1;
        DIG1:    digit_d = DIG2;
        DIG2:    digit_d = DIG3;
        default: digit_d = DIG0;
      endcase
    end
    if (boundary && !bus.FREEZE) begin
      snap_d = page_val;
      page_d = bus.PAGE_SEL;
    end
  end

  // Decode the next state into display drive. Because the outputs are registered,
  // they change on the same edge as the digit index and the snapshot.
  always_comb begin
    digit_idx = digit_d;
    an_d      = 4'b1110;
    nib       = snap_d[3:0];
    case (digit_idx)
      2'd0: begin an_d = 4'b1110; nib = snap_d[3:0];   end
      2'd1: begin an_d = 4'b1101; nib = snap_d[7:4];   end
      2'd2: begin an_d = 4'b1011; nib = snap_d[11:8];  end
      default: begin an_d = 4'b0111; nib = snap_d[15:12]; end
    endcase
`ifdef BLANK_LEADING_ZERO_EN
    // Blank every digit above the most significant nonzero nibble. A zero snapshot keeps digit 0.
    if (snap_d[15:12] != 4'h0)     blank = 1'b0;
    else if (snap_d[11:8] != 4'h0) blank = (digit_idx > 2'd2);
    else if (snap_d[7:4] != 4'h0)  blank = (digit_idx > 2'd1);
    else                           blank = (digit_idx > 2'd0);
`else
    blank = 1'b0;
`endif
    seg_d = blank ? SEG_BLANK : hex_to_seg(nib);
    // The decimal point on the top digit marks the upper half of R2.
    dp_d  = !((digit_d == DIG3) && (page_d == 2'd2));
  end

  // State and output registers. Reset lands directly on a digit-0 '0' frame, so only one anode is ever low.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q <= '0;
      digit_q <= DIG0;
      snap_q  <= 16'h0000;
      page_q  <= 2'd0;
      an_q    <= 4'b1110;
      seg_q   <= SEG_ZERO;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      snap_q  <= snap_d;
      page_q  <= page_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.AN  = an_q;
  assign bus.SEG = seg_q;
  assign bus.DP  = dp_q;

endmodule

// File: tb/tb_reg_seg_display.sv
// Directed bench for reg_seg_display with REFRESH_DIV=4 (16 cycles per full scan).
// Latency: outputs are sampled on the falling edge, away from the active rising edge.
// Backpressure: not applicable to this block.
module tb_reg_seg_display;

  logic CLK = 1'b0;
  logic RST_N;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef BLANK_LEADING_ZERO_EN
  localparam logic [6:0] Z_LEAD = 7'b1111111;
`else
  localparam logic [6:0] Z_LEAD = 7'b1000000;
`endif

  reg_seg_display_if bus();

  reg_seg_display #(.REFRESH_DIV(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Advance to the first falling edge of the next frame in which AN equals want.
  task automatic wait_frame(input logic [3:0] want);
    int n;
    n = 0;
    while (bus.AN === want && n < 64) begin @(negedge CLK); n++; end
    do begin @(negedge CLK); n++; end while (bus.AN !== want && n < 64);
    n_checks++;
    if (bus.AN !== want) begin
      n_fail++;
      $display("FAIL wait_frame: AN=%b never reached %b", bus.AN, want);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b1;
    #3 RST_N = 1'b0;
    #1;
    n_checks++; if (bus.AN  !== 4'b1110)    begin n_fail++; $display("FAIL reset_an: got %b want 1110", bus.AN); end
    n_checks++; if (bus.SEG !== 7'b1000000) begin n_fail++; $display("FAIL reset_seg: got %b want 1000000", bus.SEG); end
    n_checks++; if (bus.DP  !== 1'b1)       begin n_fail++; $display("FAIL reset_dp: got %b want 1", bus.DP); end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_checks++;
      if (bus.AN !== 4'b1110 || bus.SEG !== 7'b1000000 || bus.DP !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold%0d: got AN=%b SEG=%b DP=%b want 1110 1000000 1", c, bus.AN, bus.SEG, bus.DP);
      end
    end
    RST_N = 1'b1;
  endtask

  // Let a real snapshot (001A) load, then reset in the middle of the digit-1 frame.
  task automatic test_reset_midscan();
    wait_frame(4'b1110);
    wait_frame(4'b1101);
    n_checks++; if (bus.SEG !== 7'b1111001) begin n_fail++; $display("FAIL pre_reset_seg: got %b want 1111001", bus.SEG); end
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if (bus.AN !== 4'b1110 || bus.SEG !== 7'b1000000 || bus.DP !== 1'b1) begin
      n_fail++;
      $display("FAIL midscan_reset: got AN=%b SEG=%b DP=%b want 1110 1000000 1", bus.AN, bus.SEG, bus.DP);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_checks++;
      if (bus.AN !== 4'b1110 || bus.SEG !== 7'b1000000) begin
        n_fail++;
        $display("FAIL midscan_hold%0d: got AN=%b SEG=%b want 1110 1000000", c, bus.AN, bus.SEG);
      end
    end
    RST_N = 1'b1;
  endtask

  // First scan after release: 4 cycles per digit, snapshot still zero even though OUT_BYTE=1A.
  task automatic test_rotation();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    #1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge CLK);
      case (k / 4)
        0: begin exp_an = 4'b1110; exp_seg = 7'b1000000; end
        1: begin exp_an = 4'b1101; exp_seg = Z_LEAD; end
        2: begin exp_an = 4'b1011; exp_seg = Z_LEAD; end
        default: begin exp_an = 4'b0111; exp_seg = Z_LEAD; end
      endcase
      n_checks++; if (bus.AN !== exp_an) begin n_fail++; $display("FAIL rot_an k=%0d: got %b want %b", k, bus.AN, exp_an); end
      n_checks++; if ($countones(~bus.AN) != 1) begin n_fail++; $display("FAIL rot_onehot k=%0d: got %b want one low", k, bus.AN); end
      n_checks++; if (bus.SEG !== exp_seg) begin n_fail++; $display("FAIL rot_seg k=%0d: got %b want %b", k, bus.SEG, exp_seg); end
      n_checks++; if (bus.DP !== 1'b1) begin n_fail++; $display("FAIL rot_dp k=%0d: got %b want 1", k, bus.DP); end
    end
  endtask

  // Second scan: the snapshot 001A taken at the first boundary is now shown.
  task automatic test_page0();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    for (int k = 16; k < 32; k++) begin
      @(negedge CLK);
      case ((k - 16) / 4)
        0: begin exp_an = 4'b1110; exp_seg = 7'b0001000; end
        1: begin exp_an = 4'b1101; exp_seg = 7'b1111001; end
        2: begin exp_an = 4'b1011; exp_seg = Z_LEAD; end
        default: begin exp_an = 4'b0111; exp_seg = Z_LEAD; end
      endcase
      n_checks++; if (bus.AN !== exp_an) begin n_fail++; $display("FAIL p0_an k=%0d: got %b want %b", k, bus.AN, exp_an); end
      n_checks++; if (bus.SEG !== exp_seg) begin n_fail++; $display("FAIL p0_seg k=%0d: got %b want %b", k, bus.SEG, exp_seg); end
    end
  endtask

  // BEEF is loaded. Changing to 1234 mid-scan must wait for the next boundary.
  task automatic test_page1();
    bus.PAGE_SEL = 2'd1;
    bus.R2_WORD  = 32'h0000BEEF;
    wait_frame(4'b1110);
    n_checks++; if (bus.SEG !== 7'b0001110) begin n_fail++; $display("FAIL p1_d0_F: got %b want 0001110", bus.SEG); end
    wait_frame(4'b1101);
    n_checks++; if (bus.SEG !== 7'b0000110) begin n_fail++; $display("FAIL p1_d1_E: got %b want 0000110", bus.SEG); end
    bus.R2_WORD = 32'h00001234;
    @(negedge CLK);
    n_checks++; if (bus.SEG !== 7'b0000110) begin n_fail++; $display("FAIL p1_d1_hold: got %b want 0000110", bus.SEG); end
    wait_frame(4'b1011);
    n_checks++; if (bus.SEG !== 7'b0000110) begin n_fail++; $display("FAIL p1_d2_E: got %b want 0000110", bus.SEG); end
    wait_frame(4'b0111);
    n_checks++; if (bus.SEG !== 7'b0000011) begin n_fail++; $display("FAIL p1_d3_b: got %b want 0000011", bus.SEG); end
    n_checks++; if (bus.DP !== 1'b1) begin n_fail++; $display("FAIL p1_d3_dp: got %b want 1", bus.DP); end
    wait_frame(4'b1110);
    n_checks++; if (bus.SEG !== 7'b0011001) begin n_fail++; $display("FAIL p1_d0_4: got %b want 0011001", bus.SEG); end
    wait_frame(4'b1101);
    n_checks++; if (bus.SEG !== 7'b0110000) begin n_fail++; $display("FAIL p1_d1_3: got %b want 0110000", bus.SEG); end
    wait_frame(4'b1011);
    n_checks++; if (bus.SEG !== 7'b0100100) begin n_fail++; $display("FAIL p1_d2_2: got %b want 0100100", bus.SEG); end
    wait_frame(4'b0111);
    n_checks++; if (bus.SEG !== 7'b1111001) begin n_fail++; $display("FAIL p1_d3_1: got %b want 1111001", bus.SEG); end
  endtask

  // Upper half of R2: F000 with the decimal point only on digit 3.
  task automatic test_page2();
    logic [3:0] an_tab [4];
    logic [6:0] seg_tab [4];
    logic       dp_tab [4];
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b0001110};
    dp_tab  = '{1'b1, 1'b1, 1'b1, 1'b0};
    bus.PAGE_SEL = 2'd2;
    bus.R2_WORD  = 32'hF0000000;
    for (int d = 0; d < 4; d++) begin
      wait_frame(an_tab[d]);
      n_checks++; if (bus.SEG !== seg_tab[d]) begin n_fail++; $display("FAIL p2_seg d%0d: got %b want %b", d, bus.SEG, seg_tab[d]); end
      n_checks++; if (bus.DP !== dp_tab[d]) begin n_fail++; $display("FAIL p2_dp d%0d: got %b want %b", d, bus.DP, dp_tab[d]); end
    end
    @(negedge CLK);
    n_checks++; if (bus.DP !== 1'b0) begin n_fail++; $display("FAIL p2_dp_d3_cycle2: got %b want 0", bus.DP); end
  endtask

  // Hold F000/page2 for three scans while the inputs move, then release onto 003C page 0.
  task automatic test_freeze();
    logic [3:0] an_tab [4];
    logic [6:0] seg_tab [4];
    logic [6:0] new_tab [4];
    logic       dp_tab [4];
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b0001110};
    dp_tab  = '{1'b1, 1'b1, 1'b1, 1'b0};
    new_tab = '{7'b1000110, 7'b0110000, Z_LEAD, Z_LEAD};
    bus.FREEZE = 1'b1;
    for (int s = 0; s < 3; s++) begin
      bus.OUT_BYTE = 8'h55 + 8'(s);
      bus.PAGE_SEL = (s == 1) ? 2'd1 : 2'd0;
      bus.R2_WORD  = 32'h12345678;
      for (int d = 0; d < 4; d++) begin
        wait_frame(an_tab[d]);
        n_checks++;
        if (bus.SEG !== seg_tab[d] || bus.DP !== dp_tab[d]) begin
          n_fail++;
          $display("FAIL frz s%0d d%0d: got SEG=%b DP=%b want %b %b", s, d, bus.SEG, bus.DP, seg_tab[d], dp_tab[d]);
        end
      end
    end
    bus.FREEZE   = 1'b0;
    bus.OUT_BYTE = 8'h3C;
    bus.PAGE_SEL = 2'd0;
    for (int d = 0; d < 4; d++) begin
      wait_frame(an_tab[d]);
      n_checks++;
      if (bus.SEG !== new_tab[d] || bus.DP !== 1'b1) begin
        n_fail++;
        $display("FAIL unfrz d%0d: got SEG=%b DP=%b want %b 1", d, bus.SEG, bus.DP, new_tab[d]);
      end
    end
  endtask

  initial begin
    bus.OUT_BYTE = 8'h1A;
    bus.R2_WORD  = 32'h0;
    bus.PAGE_SEL = 2'd0;
    bus.FREEZE   = 1'b0;
    test_reset();
    test_reset_midscan();
    test_rotation();
    test_page0();
    test_page1();
    test_page2();
    test_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
